// File: rtl/screen_sequencer_pkg.sv
// Shared screen IDs and widths for the Tetris screen/mode controller.
package screen_sequencer_pkg;

   localparam int STATE_W      = 2;
   localparam int COLOUR_W_DEF = 12;

   typedef enum logic [STATE_W-1:0] {
      SCR_START = 2'd0,
      SCR_PLAY  = 2'd1,
      SCR_PAUSE = 2'd2,
      SCR_OVER  = 2'd3
   } screen_t;

endpackage

// File: rtl/screen_sequencer_rise_detect.sv
// Level to single-cycle rising-edge pulse; history clears on reset so a held level fires once.
module rise_detect (
   input  logic clk,
   input  logic resetn,
   input  logic level,
   output logic rise
);

   logic level_prev_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         level_prev_reg <= 1'b0;
      end else begin
         level_prev_reg <= level;
      end
   end

   assign rise = level & ~level_prev_reg;

endmodule

// File: rtl/screen_sequencer.sv
// Screen/mode sequencer: START/PLAY/PAUSE/OVER FSM, one-hot renderer enables,
// registered colour mux and frame-counted blanking after every screen change.
module screen_sequencer
   import screen_sequencer_pkg::*;
#(
   parameter int COLOUR_W     = COLOUR_W_DEF,
   parameter int NUM_SCREENS  = 4,
   parameter int BLANK_FRAMES = 2
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            select,
   input  logic                            pause,
   input  logic                            game_over,
   input  logic                            frame_start,
   input  logic [NUM_SCREENS*COLOUR_W-1:0] colour_in,
   output logic [COLOUR_W-1:0]             colour_out,
   output logic [NUM_SCREENS-1:0]          screen_en,
   output logic [STATE_W-1:0]              screen_id,
   output logic                            game_clear,
   output logic                            blanking
);

   localparam int CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_FRAMES);

   generate
      if (NUM_SCREENS != 4) begin : g_bad_num_screens
         $error("screen_sequencer: NUM_SCREENS must be 4");
      end
   endgenerate

   screen_t                state_reg;
   screen_t                state_next;
   logic                   game_clear_reg;
   logic                   game_clear_next;
   logic [NUM_SCREENS-1:0] screen_en_reg;
   logic [CNT_W-1:0]       blank_cnt_reg;
   logic [COLOUR_W-1:0]    colour_out_reg;
   logic                   blanking_int;
   logic                   sel_rise;
   logic                   pause_rise;
   logic [COLOUR_W-1:0]    colour_ch [NUM_SCREENS];

   rise_detect u_sel_rise (
      .clk    (clk),
      .resetn (resetn),
      .level  (select),
      .rise   (sel_rise)
   );

   rise_detect u_pause_rise (
      .clk    (clk),
      .resetn (resetn),
      .level  (pause),
      .rise   (pause_rise)
   );

   assign blanking_int = (blank_cnt_reg != '0);

   // Every input event is swallowed while blanking; the edge detectors keep tracking meanwhile.
   always_comb begin
      state_next      = state_reg;
      game_clear_next = 1'b0;
      if (!blanking_int) begin
         case (state_reg)
            SCR_START: begin
               if (sel_rise) begin
                  state_next      = SCR_PLAY;
                  game_clear_next = 1'b1;
               end
            end
            SCR_PLAY: begin
               if (game_over || sel_rise) begin
                  state_next = SCR_OVER;
               end else if (pause_rise) begin
                  state_next = SCR_PAUSE;
               end
            end
            SCR_PAUSE: begin
               if (pause_rise || sel_rise) begin
                  state_next = SCR_PLAY;
               end
            end
            SCR_OVER: begin
               if (sel_rise) begin
                  state_next = SCR_START;
               end
            end
            default: state_next = SCR_START;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= SCR_START;
         screen_en_reg  <= NUM_SCREENS'(1);
         game_clear_reg <= 1'b0;
         blank_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         game_clear_reg <= game_clear_next;
         // A screen change reloads the counter even if frame_start arrives in the same cycle.
         if (state_next != state_reg) begin
            blank_cnt_reg <= BLANK_LOAD;
            screen_en_reg <= NUM_SCREENS'(1) << state_next;
         end else if (frame_start && blanking_int) begin
            blank_cnt_reg <= blank_cnt_reg - 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SCREENS; gi++) begin : g_colour_ch
         assign colour_ch[gi] = colour_in[gi*COLOUR_W +: COLOUR_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         colour_out_reg <= '0;
      end else if (blanking_int) begin
         colour_out_reg <= '0;
      end else begin
         colour_out_reg <= colour_ch[state_reg];
      end
   end

   assign colour_out = colour_out_reg;
   assign screen_en  = screen_en_reg;
   assign screen_id  = state_reg;
   assign game_clear = game_clear_reg;
   assign blanking   = blanking_int;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboarded bench: stimulus queues expected screen transitions, a negedge monitor checks them.
module tb_screen_sequencer;

   logic        clk = 1'b0;
   logic        resetn_a = 1'b0;
   logic        resetn_b = 1'b0;
   logic        select = 1'b0;
   logic        pause = 1'b0;
   logic        game_over = 1'b0;
   logic        frame_start = 1'b0;
   logic [47:0] colour_in = {12'h00F, 12'h0F0, 12'hF00, 12'h00A};

   logic [11:0] colour_a, colour_b;
   logic [3:0]  en_a, en_b;
   logic [1:0]  id_a, id_b;
   logic        gc_a, gc_b, blank_a, blank_b;

   int checks = 0;
   int errors = 0;
   int gc_count = 0;
   logic b_blank_seen = 1'b0;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] en;
      logic       gc;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        ev;
   logic [1:0] prev_id = 2'd0;

   always #5 clk = ~clk;

   screen_sequencer #(.COLOUR_W(12), .NUM_SCREENS(4), .BLANK_FRAMES(2)) u_dut_a (
      .clk(clk), .resetn(resetn_a), .select(select), .pause(pause),
      .game_over(game_over), .frame_start(frame_start), .colour_in(colour_in),
      .colour_out(colour_a), .screen_en(en_a), .screen_id(id_a),
      .game_clear(gc_a), .blanking(blank_a)
   );

   screen_sequencer #(.COLOUR_W(12), .NUM_SCREENS(4), .BLANK_FRAMES(0)) u_dut_b (
      .clk(clk), .resetn(resetn_b), .select(select), .pause(pause),
      .game_over(game_over), .frame_start(frame_start), .colour_in(colour_in),
      .colour_out(colour_b), .screen_en(en_b), .screen_id(id_b),
      .game_clear(gc_b), .blanking(blank_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every change of screen_id on DUT A is one transaction.
   always @(negedge clk) begin
      if (id_a !== prev_id) begin
         $display("transition id %0d -> %0d en=%b gc=%b", prev_id, id_a, en_a, gc_a);
         if (exp_q.size() == 0) begin
            chk("unexpected_transition", {30'd0, id_a}, {30'd0, prev_id});
         end else begin
            ev = exp_q.pop_front();
            chk("trans_id", {30'd0, id_a}, {30'd0, ev.id});
            chk("trans_en", {28'd0, en_a}, {28'd0, ev.en});
            chk("trans_gc", {31'd0, gc_a}, {31'd0, ev.gc});
         end
      end
      prev_id = id_a;
      if (gc_a === 1'b1) gc_count++;
      if (resetn_b && blank_b) b_blank_seen = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic clear_blank();
      pulse_frame();
      pulse_frame();
   endtask

   task automatic press_sel();
      select = 1'b1;
      step();
      step();
      select = 1'b0;
      step();
   endtask

   task automatic press_pause();
      pause = 1'b1;
      step();
      step();
      pause = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_id", {30'd0, id_a}, 32'd0);
      chk("rst_en", {28'd0, en_a}, 32'h1);
      chk("rst_colour", {20'd0, colour_a}, 32'h0);
      chk("rst_blank", {31'd0, blank_a}, 32'd0);
      chk("rst_gc", {31'd0, gc_a}, 32'd0);
      step();
      resetn_a = 1'b1;
      step();
      @(negedge clk);
      chk("post_rst_colour", {20'd0, colour_a}, 32'h00A);

      // Held select: one START->PLAY
      step();
      exp_q.push_back('{id: 2'd1, en: 4'b0010, gc: 1'b1});
      select = 1'b1;
      for (int i = 0; i < 100; i++) step();
      select = 1'b0;
      step();

      // Blanking for two frames
      @(negedge clk);
      chk("blank_colour0", {20'd0, colour_a}, 32'h0);
      chk("blank_flag0", {31'd0, blank_a}, 32'd1);
      step();
      pulse_frame();
      @(negedge clk);
      chk("blank_flag1", {31'd0, blank_a}, 32'd1);
      step();
      pulse_frame();
      @(negedge clk);
      chk("blank_end_flag", {31'd0, blank_a}, 32'd0);
      chk("blank_end_colour", {20'd0, colour_a}, 32'h0);
      step();
      @(negedge clk);
      chk("play_colour", {20'd0, colour_a}, 32'hF00);
      step();

      // game_over and select together -> OVER once
      exp_q.push_back('{id: 2'd3, en: 4'b1000, gc: 1'b0});
      game_over = 1'b1;
      select = 1'b1;
      step();
      game_over = 1'b0;
      step(); step();
      select = 1'b0;
      step();
      clear_blank();

      // OVER -> START -> PLAY -> PAUSE
      exp_q.push_back('{id: 2'd0, en: 4'b0001, gc: 1'b0});
      press_sel();
      clear_blank();
      exp_q.push_back('{id: 2'd1, en: 4'b0010, gc: 1'b1});
      press_sel();
      clear_blank();
      exp_q.push_back('{id: 2'd2, en: 4'b0100, gc: 1'b0});
      press_pause();
      // pause pressed and held through blanking: never fires
      pause = 1'b1;
      step(); step(); step();
      clear_blank();
      step(); step(); step();
      pause = 1'b0;
      step();
      exp_q.push_back('{id: 2'd1, en: 4'b0010, gc: 1'b0});
      press_sel();
      clear_blank();

      // PAUSE with one blank frame left, then async reset
      exp_q.push_back('{id: 2'd2, en: 4'b0100, gc: 1'b0});
      press_pause();
      pulse_frame();
      @(negedge clk);
      chk("pause_blank1", {31'd0, blank_a}, 32'd1);
      exp_q.push_back('{id: 2'd0, en: 4'b0001, gc: 1'b0});
      @(posedge clk);
      #3;
      resetn_a = 1'b0;
      #1;
      chk("async_id", {30'd0, id_a}, 32'd0);
      chk("async_en", {28'd0, en_a}, 32'h1);
      chk("async_colour", {20'd0, colour_a}, 32'h0);
      chk("async_blank", {31'd0, blank_a}, 32'd0);
      step(); step();

      // BLANK_FRAMES=0 instance
      resetn_b = 1'b1;
      step(); step();
      select = 1'b1;
      step();
      @(negedge clk);
      chk("b_id", {30'd0, id_b}, 32'd1);
      chk("b_gc", {31'd0, gc_b}, 32'd1);
      chk("b_blank", {31'd0, blank_b}, 32'd0);
      step();
      @(negedge clk);
      chk("b_colour", {20'd0, colour_b}, 32'hF00);
      select = 1'b0;
      step(); step();

      @(negedge clk);
      chk("gc_pulses", gc_count, 32'd2);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("b_never_blank", {31'd0, b_blank_seen}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
